// File: rtl/led_receiver_if.sv
// Signal bundle for the one-wire LED-strip receiver: data in, decoded word, status pulses,
// and the forwarded data line.
interface led_receiver_if;
    logic        din;
    logic [23:0] rgb;
    logic        valid;
    logic        frame_end;
    logic        err;
    logic        dout;

    modport master (
        output din,
        input  rgb, valid, frame_end, err, dout
    );

    modport slave (
        input  din,
        output rgb, valid, frame_end, err, dout
    );
endinterface

// File: rtl/led_receiver.sv
// One-wire LED-strip receiver: pulse-width decode of din into 24-bit words.
// Define LED_RECEIVER_FORWARD_EN to consume the first word per frame and forward the rest on dout.
module led_receiver #(
    parameter int unsigned T_THRESH = 30,
    parameter int unsigned MIN_HIGH = 4,
    parameter int unsigned MAX_HIGH = 80,
    parameter int unsigned GAP      = 2500
) (
    input logic           clk,
    input logic           rst,
    led_receiver_if.slave bus
);

    localparam logic [11:0] T_THRESH_C = 12'(T_THRESH);
    localparam logic [11:0] MIN_HIGH_C = 12'(MIN_HIGH);
    localparam logic [11:0] MAX_HIGH_C = 12'(MAX_HIGH);
    localparam logic [11:0] GAP_C      = 12'(GAP);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StRecover} state_e;

    state_e      state_q, state_d;
    logic        sync_q, din_s_q, din_d_q;
    logic [11:0] hc_q, hc_d, lc_q, lc_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q, shift_d, rgb_q, rgb_d;
    logic        word_done_q, word_done_d;
    logic        valid_q, valid_d, frame_end_q, frame_end_d, err_q, err_d;
    logic        rise, fall, decode_en;
    logic [11:0] lc_inc;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hfff) ? v : v + 12'd1;
    endfunction

    assign rise   = din_s_q & ~din_d_q;
    assign fall   = ~din_s_q & din_d_q;
    assign lc_inc = sat_inc(lc_q);

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        lc_d        = lc_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rgb_d       = rgb_q;
        word_done_d = 1'b0;
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        err_d       = 1'b0;

        // The 24th bit landed last cycle; publish the completed word now.
        if (word_done_q) begin
            rgb_d     = shift_q;
            valid_d   = 1'b1;
            bit_cnt_d = 5'd0;
        end

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    hc_d    = 12'd1;
                end
            end
            StHigh: begin
                if (fall) begin
                    state_d = StLow;
                    lc_d    = 12'd1;
                    if (hc_q < MIN_HIGH_C) begin
                        err_d     = 1'b1;
                        bit_cnt_d = 5'd0;
                    end else if (decode_en) begin
                        shift_d = {shift_q[22:0], (hc_q >= T_THRESH_C)};
                        if (bit_cnt_q == 5'd23) word_done_d = 1'b1;
                        else                    bit_cnt_d   = bit_cnt_q + 5'd1;
                    end
                end else if (hc_q >= MAX_HIGH_C) begin
                    // This cycle is high cycle MAX_HIGH+1: the pulse is overlong.
                    state_d   = StRecover;
                    err_d     = 1'b1;
                    bit_cnt_d = 5'd0;
                    shift_d   = 24'd0;
                    lc_d      = 12'd0;
                end else begin
                    hc_d = sat_inc(hc_q);
                end
            end
            StLow: begin
                if (rise) begin
                    state_d = StHigh;
                    hc_d    = 12'd1;
                end else begin
                    lc_d = lc_inc;
                    if (lc_inc >= GAP_C) begin
                        state_d     = StIdle;
                        frame_end_d = 1'b1;
                        bit_cnt_d   = 5'd0;
                    end
                end
            end
            StRecover: begin
                if (din_s_q) begin
                    lc_d = 12'd0;
                end else begin
                    lc_d = lc_inc;
                    if (lc_inc >= GAP_C) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            sync_q      <= 1'b0;
            din_s_q     <= 1'b0;
            din_d_q     <= 1'b0;
            hc_q        <= 12'd0;
            lc_q        <= 12'd0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 24'd0;
            rgb_q       <= 24'd0;
            word_done_q <= 1'b0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= bus.din;
            din_s_q     <= sync_q;
            din_d_q     <= din_s_q;
            hc_q        <= hc_d;
            lc_q        <= lc_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rgb_q       <= rgb_d;
            word_done_q <= word_done_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
        end
    end

`ifdef LED_RECEIVER_FORWARD_EN
    logic fwd_q, dout_q;

    // Once our own word is taken, stop decoding and pass the line through until the gap.
    assign decode_en = ~fwd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            if (frame_end_d)  fwd_q <= 1'b0;
            else if (valid_d) fwd_q <= 1'b1;
            dout_q <= fwd_q & din_s_q;
        end
    end

    assign bus.dout = dout_q;
`else
    assign decode_en = 1'b1;
    assign bus.dout  = 1'b0;
`endif

    assign bus.rgb       = rgb_q;
    assign bus.valid     = valid_q;
    assign bus.frame_end = frame_end_q;
    assign bus.err       = err_q;

endmodule
